// File: rtl/pipe_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : pipe_scoreboard
// Purpose  : Register-hazard tracker for the post-decode pipeline stages.
//            Each tracked stage holds a destination register and the number
//            of advances left until its result exists. Each read port gets
//            one of three answers: forward from the youngest matching stage,
//            stall because that stage is not ready yet, or use the register
//            file.
// Options  : SCOREBOARD_RETIRE_BYPASS_EN - adds an always-ready entry R that
//            holds the entry retired on the last advance. A hit on R reports
//            stage index DEPTH.
// Ports    : clk, reset (async, active-high)
//            advance, clear            - pipeline control
//            issue_valid/dest/lat      - instruction entering entry 0
//            rd_en, rd_addr            - per-port lookups (packed)
//            rd_stall, rd_hit,
//            rd_fwd_stage, any_stall   - per-port lookup results
//            occupancy                 - number of valid entries
// Revision : 1.0 - initial release
// ============================================================================
module pipe_scoreboard #(
    parameter int DEPTH  = 4,
    parameter int NREAD  = 2,
    parameter int REG_AW = 5,
    parameter int LAT_W  = 3,
    parameter int SW     = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    advance,
    input  logic                    clear,
    input  logic                    issue_valid,
    input  logic [REG_AW-1:0]       issue_dest,
    input  logic [LAT_W-1:0]        issue_lat,
    input  logic [NREAD-1:0]        rd_en,
    input  logic [NREAD*REG_AW-1:0] rd_addr,
    output logic [NREAD-1:0]        rd_stall,
    output logic [NREAD-1:0]        rd_hit,
    output logic [NREAD*SW-1:0]     rd_fwd_stage,
    output logic                    any_stall,
    output logic [SW-1:0]           occupancy
);

    localparam int c_MAX_REM = DEPTH - 1;

    // Entry 0 is the youngest stage, entry DEPTH-1 the oldest.
    logic [DEPTH-1:0]             r_valid;
    logic [DEPTH-1:0][REG_AW-1:0] r_dest;
    logic [DEPTH-1:0][LAT_W-1:0]  r_rem;
    logic [SW-1:0]                r_occupancy;

    logic [DEPTH-1:0]             w_validNext;
    logic [DEPTH-1:0][REG_AW-1:0] w_destNext;
    logic [DEPTH-1:0][LAT_W-1:0]  w_remNext;
    logic [LAT_W-1:0]             w_issueRem;

`ifdef SCOREBOARD_RETIRE_BYPASS_EN
    logic              r_retValid;
    logic [REG_AW-1:0] r_retDest;
    logic              w_retValidNext;
    logic [REG_AW-1:0] w_retDestNext;
`endif

    function automatic logic [SW-1:0] f_popcount(input logic [DEPTH-1:0] v);
        logic [SW-1:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + SW'(v[i]);
        end
        return n;
    endfunction

    // A latency longer than the table can never be waited out inside it,
    // so it is clamped to the oldest stage.
    assign w_issueRem = (int'(issue_lat) > c_MAX_REM) ? LAT_W'(c_MAX_REM) : issue_lat;

    always_comb begin
        w_validNext = r_valid;
        w_destNext  = r_dest;
        w_remNext   = r_rem;
`ifdef SCOREBOARD_RETIRE_BYPASS_EN
        w_retValidNext = r_retValid;
        w_retDestNext  = r_retDest;
`endif
        if (clear) begin
            w_validNext = '0;
`ifdef SCOREBOARD_RETIRE_BYPASS_EN
            w_retValidNext = 1'b0;
`endif
        end else if (advance) begin
            for (int i = 1; i < DEPTH; i++) begin
                w_validNext[i] = r_valid[i-1];
                w_destNext[i]  = r_dest[i-1];
                w_remNext[i]   = (r_rem[i-1] == '0) ? '0 : r_rem[i-1] - 1'b1;
            end
            // Writes to r0 are discarded, so they occupy the slot as a bubble.
            w_validNext[0] = issue_valid && (issue_dest != '0);
            w_destNext[0]  = issue_dest;
            w_remNext[0]   = w_issueRem;
`ifdef SCOREBOARD_RETIRE_BYPASS_EN
            w_retValidNext = r_valid[DEPTH-1];
            w_retDestNext  = r_dest[DEPTH-1];
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid     <= '0;
            r_dest      <= '0;
            r_rem       <= '0;
            r_occupancy <= '0;
`ifdef SCOREBOARD_RETIRE_BYPASS_EN
            r_retValid  <= 1'b0;
            r_retDest   <= '0;
`endif
        end else begin
            r_valid     <= w_validNext;
            r_dest      <= w_destNext;
            r_rem       <= w_remNext;
            r_occupancy <= f_popcount(w_validNext);
`ifdef SCOREBOARD_RETIRE_BYPASS_EN
            r_retValid  <= w_retValidNext;
            r_retDest   <= w_retDestNext;
`endif
        end
    end

    assign occupancy = r_occupancy;

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        logic [REG_AW-1:0] w_addr;
        logic              w_found;
        logic              w_ready;
        logic [SW-1:0]     w_stage;

        assign w_addr = rd_addr[p*REG_AW +: REG_AW];

        // Scan from oldest to youngest so the youngest match wins. A
        // not-ready young match therefore hides any ready older one.
        always_comb begin
            w_found = 1'b0;
            w_ready = 1'b0;
            w_stage = '0;
`ifdef SCOREBOARD_RETIRE_BYPASS_EN
            if (r_retValid && (r_retDest == w_addr)) begin
                w_found = 1'b1;
                w_ready = 1'b1;
                w_stage = SW'(DEPTH);
            end
`endif
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (r_valid[i] && (r_dest[i] == w_addr)) begin
                    w_found = 1'b1;
                    w_ready = (r_rem[i] == '0);
                    w_stage = SW'(i);
                end
            end
            if (!rd_en[p] || (w_addr == '0)) begin
                w_found = 1'b0;
            end
        end

        assign rd_hit[p]                  = w_found && w_ready;
        assign rd_stall[p]                = w_found && !w_ready;
        assign rd_fwd_stage[p*SW +: SW]   = w_found ? w_stage : '0;
    end

    assign any_stall = |rd_stall;

endmodule
`default_nettype wire

// File: tb/tb_pipe_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_scoreboard
// Purpose  : Directed self-checking bench for pipe_scoreboard (default
//            parameters). Expected values are hand-derived per step.
//            Honours SCOREBOARD_RETIRE_BYPASS_EN for the retire-entry steps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_scoreboard;

    localparam int DEPTH  = 4;
    localparam int NREAD  = 2;
    localparam int REG_AW = 5;
    localparam int LAT_W  = 3;
    localparam int SW     = 3;

    logic                    clk;
    logic                    reset;
    logic                    advance;
    logic                    clear;
    logic                    issue_valid;
    logic [REG_AW-1:0]       issue_dest;
    logic [LAT_W-1:0]        issue_lat;
    logic [NREAD-1:0]        rd_en;
    logic [NREAD*REG_AW-1:0] rd_addr;
    logic [NREAD-1:0]        rd_stall;
    logic [NREAD-1:0]        rd_hit;
    logic [NREAD*SW-1:0]     rd_fwd_stage;
    logic                    any_stall;
    logic [SW-1:0]           occupancy;

    int total;
    int bad;

    pipe_scoreboard #(
        .DEPTH (DEPTH),
        .NREAD (NREAD),
        .REG_AW(REG_AW),
        .LAT_W (LAT_W),
        .SW    (SW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .advance     (advance),
        .clear       (clear),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .issue_lat   (issue_lat),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_stall    (rd_stall),
        .rd_hit      (rd_hit),
        .rd_fwd_stage(rd_fwd_stage),
        .any_stall   (any_stall),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given control; returns 1 time unit after it.
    task automatic tick(input logic adv, input logic clr, input logic iv,
                        input logic [REG_AW-1:0] dst, input logic [LAT_W-1:0] lat);
        advance     = adv;
        clear       = clr;
        issue_valid = iv;
        issue_dest  = dst;
        issue_lat   = lat;
        @(posedge clk);
        #1;
        advance     = 1'b0;
        clear       = 1'b0;
        issue_valid = 1'b0;
        issue_dest  = '0;
        issue_lat   = '0;
    endtask

    task automatic look(input logic [NREAD-1:0] en, input logic [REG_AW-1:0] a0,
                        input logic [REG_AW-1:0] a1);
        rd_en   = en;
        rd_addr = {a1, a0};
        #1;
    endtask

    // Port p result as {hit, stall, stage}.
    function automatic logic [31:0] port(input int p);
        return {27'd0, rd_hit[p], rd_stall[p], rd_fwd_stage[p*SW +: SW]};
    endfunction

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        advance     = 1'b0;
        clear       = 1'b0;
        issue_valid = 1'b0;
        issue_dest  = '0;
        issue_lat   = '0;
        rd_en       = '0;
        rd_addr     = '0;

        // Reset state, with lookups enabled on a register nothing writes.
        #2;
        look(2'b11, 5'd5, 5'd8);
        check("rst_p0", port(0), 32'h0);
        check("rst_p1", port(1), 32'h0);
        check("rst_any", 32'(any_stall), 32'h0);
        check("rst_occ", 32'(occupancy), 32'h0);
        #10 reset = 1'b0;

        // 1: r5 lat 0 walks through every stage and retires.
        tick(1'b1, 1'b0, 1'b1, 5'd5, 3'd0);
        look(2'b01, 5'd5, 5'd0);
        check("t1_s0", port(0), {27'd0, 1'b1, 1'b0, 3'd0});
        check("t1_occ1", 32'(occupancy), 32'd1);
        tick(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
        check("t1_s1", port(0), {27'd0, 1'b1, 1'b0, 3'd1});
        tick(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
        check("t1_s2", port(0), {27'd0, 1'b1, 1'b0, 3'd2});
        tick(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
        check("t1_s3", port(0), {27'd0, 1'b1, 1'b0, 3'd3});
        tick(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
`ifdef SCOREBOARD_RETIRE_BYPASS_EN
        check("t1_ret", port(0), {27'd0, 1'b1, 1'b0, 3'd4});
`else
        check("t1_ret", port(0), 32'h0);
`endif
        check("t1_occ0", 32'(occupancy), 32'd0);
        tick(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
        check("t1_gone", port(0), 32'h0);

        // 2: r8 lat 2 stalls for two stages, then forwards from stage 2.
        tick(1'b1, 1'b0, 1'b1, 5'd8, 3'd2);
        look(2'b01, 5'd8, 5'd0);
        check("t2_st0", port(0), {27'd0, 1'b0, 1'b1, 3'd0});
        check("t2_any0", 32'(any_stall), 32'd1);
        tick(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
        check("t2_st1", port(0), {27'd0, 1'b0, 1'b1, 3'd1});
        tick(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
        check("t2_hit2", port(0), {27'd0, 1'b1, 1'b0, 3'd2});
        check("t2_any2", 32'(any_stall), 32'd0);
        tick(1'b0, 1'b1, 1'b0, 5'd0, 3'd0);

        // 3: young not-ready r3 hides the ready older r3; port 1 misses.
        tick(1'b1, 1'b0, 1'b1, 5'd3, 3'd0);
        tick(1'b1, 1'b0, 1'b1, 5'd3, 3'd1);
        look(2'b11, 5'd3, 5'd5);
        check("t3_p0", port(0), {27'd0, 1'b0, 1'b1, 3'd0});
        check("t3_p1", port(1), 32'h0);
        check("t3_occ", 32'(occupancy), 32'd2);
        look(2'b10, 5'd3, 5'd3);
        check("t3_en0", port(0), 32'h0);
        check("t3_p1b", port(1), {27'd0, 1'b0, 1'b1, 3'd0});
        tick(1'b0, 1'b1, 1'b0, 5'd0, 3'd0);

        // 4: writes to r0 become bubbles; r0 lookups never hit.
        tick(1'b1, 1'b0, 1'b1, 5'd0, 3'd0);
        look(2'b11, 5'd0, 5'd0);
        check("t4_p0", port(0), 32'h0);
        check("t4_p1", port(1), 32'h0);
        check("t4_occ", 32'(occupancy), 32'd0);

        // 5: hold keeps rem; issue during hold is ignored; clear wins.
        tick(1'b1, 1'b0, 1'b1, 5'd8, 3'd2);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b0, 1'b1, 5'd7, 3'd0);
        end
        look(2'b11, 5'd8, 5'd7);
        check("t5_hold", port(0), {27'd0, 1'b0, 1'b1, 3'd0});
        check("t5_ign", port(1), 32'h0);
        check("t5_occ", 32'(occupancy), 32'd1);
        tick(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
        check("t5_rem", port(0), {27'd0, 1'b0, 1'b1, 3'd1});
        tick(1'b1, 1'b1, 1'b1, 5'd7, 3'd0);
        check("t5_clr", port(0), 32'h0);
        check("t5_clrany", 32'(any_stall), 32'd0);
        check("t5_clriss", port(1), 32'h0);
        check("t5_clrocc", 32'(occupancy), 32'd0);

        // Latency beyond the table clamps to DEPTH-1: ready at stage 3.
        tick(1'b1, 1'b0, 1'b1, 5'd12, 3'd7);
        look(2'b01, 5'd12, 5'd0);
        tick(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
        tick(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
        check("t5_clamp2", port(0), {27'd0, 1'b0, 1'b1, 3'd2});
        tick(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
        check("t5_clamp3", port(0), {27'd0, 1'b1, 1'b0, 3'd3});
        tick(1'b0, 1'b1, 1'b0, 5'd0, 3'd0);

        // 6a: r9 retires from stage 3; R clears on the following advance.
        tick(1'b1, 1'b0, 1'b1, 5'd9, 3'd0);
        tick(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
        tick(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
        tick(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
        look(2'b01, 5'd9, 5'd0);
        check("t6_s3", port(0), {27'd0, 1'b1, 1'b0, 3'd3});
        tick(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
`ifdef SCOREBOARD_RETIRE_BYPASS_EN
        check("t6_ret", port(0), {27'd0, 1'b1, 1'b0, 3'd4});
`else
        check("t6_ret", port(0), 32'h0);
`endif
        tick(1'b1, 1'b0, 1'b0, 5'd0, 3'd0);
        check("t6_retclr", port(0), 32'h0);

        // 6b: three live entries, then async reset between edges.
        tick(1'b1, 1'b0, 1'b1, 5'd9, 3'd0);
        tick(1'b1, 1'b0, 1'b1, 5'd10, 3'd0);
        tick(1'b1, 1'b0, 1'b1, 5'd11, 3'd1);
        look(2'b11, 5'd11, 5'd9);
        check("t6_pre0", port(0), {27'd0, 1'b0, 1'b1, 3'd0});
        check("t6_pre1", port(1), {27'd0, 1'b1, 1'b0, 3'd2});
        check("t6_preocc", 32'(occupancy), 32'd3);
        #2 reset = 1'b1;
        #1;
        check("t6_rst0", port(0), 32'h0);
        check("t6_rst1", port(1), 32'h0);
        check("t6_rstany", 32'(any_stall), 32'd0);
        check("t6_rstocc", 32'(occupancy), 32'd0);
        #2 reset = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 5'd0, 3'd0);
        check("t6_post", port(0), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
